// File: rtl/alu_pkg.sv
// Shared opcode and FSM state definitions for the bit-serial ALU sequencer and its one-bit cell.
package alu_pkg;

   localparam logic [2:0] OP_PASS = 3'b000;
   localparam logic [2:0] OP_NOT  = 3'b001;
   localparam logic [2:0] OP_XOR  = 3'b010;
   localparam logic [2:0] OP_XNOR = 3'b011;
   localparam logic [2:0] OP_OR   = 3'b110;
   localparam logic [2:0] OP_NORB = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/one.sv
// One-bit ALU cell: each output bit is one opcode's result, gated so at most one bit can be high.
module one
   import alu_pkg::*;
(
   input  logic       M,
   input  logic       A,
   input  logic       B,
   input  logic       S0,
   input  logic       S1,
   output logic [5:0] out
);

   logic [2:0] w_op;

   assign w_op = {M, S1, S0};

   // PASS and NOT ignore M, so only the low two opcode bits are decoded for them.
   assign out[0] = (w_op[1:0] == OP_PASS[1:0]) & A;
   assign out[1] = (w_op[1:0] == OP_NOT[1:0])  & ~A;
   assign out[2] = (w_op == OP_XOR)  & (A ^ B);
   assign out[3] = (w_op == OP_XNOR) & ~(A ^ B);
   assign out[4] = (w_op == OP_OR)   & (A | B);
   assign out[5] = (w_op == OP_NORB) & (~A | B);

endmodule

// File: rtl/alu_serial_seq.sv
// Bit-serial sequencer: latches operands on start, steps the one-bit cell LSB first, and
// publishes the collected result with a one-cycle done pulse.
module alu_serial_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             zero
);

   state_t           r_state;
   state_t           w_state_n;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_a_sh;
   logic [WIDTH-1:0] r_b_sh;
   logic [2:0]       r_op_q;
   logic [WIDTH-1:0] r_res_sh;
   logic [WIDTH-1:0] r_result;
   logic             r_zero;

   logic             w_accept;
   logic             w_last;
   logic [5:0]       w_cell;
   logic             w_bit;
   logic [WIDTH-1:0] w_res_next;

   one u_one (
      .M   (r_op_q[2]),
      .A   (r_a_sh[0]),
      .B   (r_b_sh[0]),
      .S0  (r_op_q[0]),
      .S1  (r_op_q[1]),
      .out (w_cell)
   );

   assign w_bit      = |w_cell;
   assign w_res_next = {w_bit, r_res_sh[WIDTH-1:1]};
   assign w_last     = (r_state == S_RUN) && (r_cnt == CNT_W'(WIDTH - 1));

   always_comb begin
      w_state_n = r_state;
      w_accept  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_n = S_RUN;
               w_accept  = 1'b1;
            end
         end
         S_RUN: begin
            if (w_last) w_state_n = S_DONE;
         end
         S_DONE: begin
            if (start) begin
               w_state_n = S_RUN;
               w_accept  = 1'b1;
            end else begin
               w_state_n = S_IDLE;
            end
         end
         default: w_state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_a_sh   <= '0;
         r_b_sh   <= '0;
         r_op_q   <= '0;
         r_res_sh <= '0;
         r_result <= '0;
         r_zero   <= 1'b1;
      end else begin
         r_state <= w_state_n;
         if (w_accept) begin
            r_a_sh <= a;
            r_b_sh <= b;
            r_op_q <= op;
            r_cnt  <= '0;
         end else if (r_state == S_RUN) begin
            r_a_sh   <= r_a_sh >> 1;
            r_b_sh   <= r_b_sh >> 1;
            r_res_sh <= w_res_next;
            // Counter holds at WIDTH-1 on the final bit rather than stepping past it.
            if (!w_last) r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
               r_result <= w_res_next;
               r_zero   <= (w_res_next == '0);
            end
         end
      end
   end

   assign busy   = (r_state == S_RUN);
   assign done   = (r_state == S_DONE);
   assign result = r_result;
   assign zero   = r_zero;

endmodule

// File: tb/tb_alu_serial_seq.sv
// Randomized bench for alu_serial_seq: an operation-level model predicts busy/done/result/zero
// every cycle, and directed cases pin the model with hand-computed values.
module tb_alu_serial_seq;

   localparam int W = 8;

   logic         clk;
   logic         reset;
   logic         start;
   logic [2:0]   op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         zero;

   int errors = 0;
   int checks = 0;
   int n_done = 0;
   int cyc    = 0;

   alu_serial_seq #(.WIDTH(W), .CNT_W(5)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .op     (op),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .result (result),
      .zero   (zero)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // behavioural reference: an operation is W busy cycles, then one done cycle
   function automatic logic [W-1:0] alu_f(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      case (o)
         3'b000, 3'b100: return x;
         3'b001, 3'b101: return ~x;
         3'b010:         return x ^ y;
         3'b011:         return ~(x ^ y);
         3'b110:         return x | y;
         default:        return ~x | y;
      endcase
   endfunction

   int           m_rem   = 0;
   logic [W-1:0] m_pend  = '0;
   logic         m_busy  = 1'b0;
   logic         m_done  = 1'b0;
   logic [W-1:0] m_res   = '0;
   logic         m_zero  = 1'b1;
   logic         m_valid = 1'b0;

   always @(posedge clk) begin
      m_valid = 1'b1;
      if (reset) begin
         m_rem  = 0;
         m_busy = 1'b0;
         m_done = 1'b0;
         m_res  = '0;
         m_zero = 1'b1;
      end else begin
         m_done = 1'b0;
         if (m_rem > 0) begin
            m_rem = m_rem - 1;
            if (m_rem == 0) begin
               m_res  = m_pend;
               m_zero = (m_pend == '0);
               m_done = 1'b1;
            end
         end else if (start) begin
            m_pend = alu_f(op, a, b);
            m_rem  = W;
         end
         m_busy = (m_rem > 0);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // compare process, away from the active edge
   always @(negedge clk) begin
      cyc++;
      if (done) n_done++;
      if (m_valid) begin
         chk("busy",   32'(busy),   32'(m_busy));
         chk("done",   32'(done),   32'(m_done));
         chk("result", 32'(result), 32'(m_res));
         chk("zero",   32'(zero),   32'(m_zero));
      end
   end

   // driver tasks
   task automatic wait_done(output int lat);
      lat = 1;
      while (!done && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      if (!done) chk("done_timeout", 32'(0), 32'(1));
   endtask

   task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y, output int lat);
      op    = o;
      a     = x;
      b     = y;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a     = W'($urandom);
      b     = W'($urandom);
      op    = 3'($urandom);
      wait_done(lat);
   endtask

   int lat;
   int d0;
   int c0;
   int c1;

   initial begin
      reset = 1'b1;
      start = 1'b0;
      op    = '0;
      a     = '0;
      b     = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_done", 32'(done), 32'(0));
      chk("rst_result", 32'(result), 32'(8'h00));
      chk("rst_zero", 32'(zero), 32'(1));
      reset = 1'b0;
      repeat (5) @(negedge clk);
      chk("idle_result", 32'(result), 32'(8'h00));
      chk("idle_zero", 32'(zero), 32'(1));

      run_op(3'b010, 8'hA5, 8'h0F, lat);
      chk("xor_lat", 32'(lat), 32'(W + 1));
      chk("xor_res", 32'(result), 32'(8'hAA));
      chk("xor_zero", 32'(zero), 32'(0));
      @(negedge clk);
      run_op(3'b111, 8'hF0, 8'h0C, lat);
      chk("norb_res", 32'(result), 32'(8'h0F));
      @(negedge clk);
      run_op(3'b110, 8'h00, 8'h00, lat);
      chk("or0_res", 32'(result), 32'(8'h00));
      chk("or0_zero", 32'(zero), 32'(1));
      @(negedge clk);
      run_op(3'b001, 8'h3C, 8'h00, lat);
      chk("not_res", 32'(result), 32'(8'hC3));
      @(negedge clk);

      // start during RUN is ignored; operands changed mid-flight have no effect
      d0    = n_done;
      op    = 3'b000;
      a     = 8'h5A;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      a     = 8'hFF;
      op    = 3'b001;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(lat);
      chk("midrun_res", 32'(result), 32'(8'h5A));
      repeat (12) @(negedge clk);
      chk("midrun_ndone", 32'(n_done - d0), 32'(1));
      chk("midrun_idle", 32'(busy), 32'(0));

      // reset mid-RUN discards the operation
      d0    = n_done;
      op    = 3'b010;
      a     = 8'h3C;
      b     = 8'h81;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort_busy", 32'(busy), 32'(0));
      chk("abort_result", 32'(result), 32'(8'h00));
      chk("abort_zero", 32'(zero), 32'(1));
      repeat (12) @(negedge clk);
      chk("abort_ndone", 32'(n_done - d0), 32'(0));

      // back-to-back with start held high
      op    = 3'b011;
      a     = 8'h0F;
      b     = 8'h0F;
      start = 1'b1;
      @(negedge clk);
      op = 3'b010;
      a  = 8'hFF;
      b  = 8'h00;
      wait_done(lat);
      c0 = cyc;
      chk("b2b_res1", 32'(result), 32'(8'hFF));
      @(negedge clk);
      start = 1'b0;
      wait_done(lat);
      c1 = cyc;
      chk("b2b_res2", 32'(result), 32'(8'hFF));
      chk("b2b_gap", 32'(c1 - c0), 32'(W + 1));
      repeat (2) @(negedge clk);

      // randomized operations, sometimes back-to-back
      for (int i = 0; i < 40; i++) begin
         run_op(3'($urandom_range(0, 7)), W'($urandom), W'($urandom), lat);
         chk("rand_lat", 32'(lat), 32'(W + 1));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      repeat (3) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
